// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-ported synchronous memory.
// Each transaction walks IDLE -> ISSUE -> RESP, so an ack lands two cycles after the grant.
module mem_arbiter #(
    parameter int RR_MODE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    output logic [31:0] i_wait_cnt
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        owner_is_d_q, owner_is_d_d;
    logic        last_is_d_q, last_is_d_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        pick_d;

    // On a tie, round-robin hands the grant to whichever port did not win last time.
    assign pick_d = d_req && (!i_req || (RR_MODE == 0) || !last_is_d_q);

    always_comb begin
        state_d      = state_q;
        owner_is_d_d = owner_is_d_q;
        last_is_d_d  = last_is_d_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        wait_cnt_d   = wait_cnt_q + {31'd0, (i_req && !i_ack)};
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d      = ISSUE;
                    owner_is_d_d = pick_d;
                    last_is_d_d  = pick_d;
                    addr_d       = pick_d ? d_addr  : i_addr;
                    wdata_d      = pick_d ? d_wdata : 32'd0;
                    wmask_d      = pick_d ? d_wmask : 4'd0;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_is_d_q <= 1'b0;
            last_is_d_q  <= 1'b1;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wmask_q      <= 4'd0;
            wait_cnt_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_is_d_q <= owner_is_d_d;
            last_is_d_q  <= last_is_d_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    // Strobes and acks decode straight from the state so reset silences them at once.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_rstrb = (state_q == ISSUE) && (wmask_q == 4'd0);
        mem_wmask = (state_q == ISSUE) ? wmask_q : 4'd0;
        i_ack     = (state_q == RESP) && !owner_is_d_q;
        d_ack     = (state_q == RESP) && owner_is_d_q;
        i_rdata   = i_ack ? mem_rdata : 32'd0;
        d_rdata   = d_ack ? mem_rdata : 32'd0;
    end

    assign i_wait_cnt = wait_cnt_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Checks a round-robin and a fixed-priority arbiter, driven by shared stimulus, against a
// transaction-schedule model: a grant at cycle T means strobe at T+1, ack at T+2, free at T+3.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_wmask = '0;

    logic [31:0] i_rdata_w [2];
    logic [31:0] d_rdata_w [2];
    logic [31:0] mem_addr_w [2];
    logic [31:0] mem_wdata_w [2];
    logic [31:0] wait_w [2];
    logic [3:0]  mem_wmask_w [2];
    logic        i_ack_w [2];
    logic        d_ack_w [2];
    logic        mem_rstrb_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.RR_MODE(1)) u_rr (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata_w[0]), .i_ack(i_ack_w[0]),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_rdata(d_rdata_w[0]), .d_ack(d_ack_w[0]),
        .mem_addr(mem_addr_w[0]), .mem_rstrb(mem_rstrb_w[0]), .mem_wdata(mem_wdata_w[0]),
        .mem_wmask(mem_wmask_w[0]), .mem_rdata(mem_rdata), .i_wait_cnt(wait_w[0])
    );

    mem_arbiter #(.RR_MODE(0)) u_fp (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata_w[1]), .i_ack(i_ack_w[1]),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_rdata(d_rdata_w[1]), .d_ack(d_ack_w[1]),
        .mem_addr(mem_addr_w[1]), .mem_rstrb(mem_rstrb_w[1]), .mem_wdata(mem_wdata_w[1]),
        .mem_wmask(mem_wmask_w[1]), .mem_rdata(mem_rdata), .i_wait_cnt(wait_w[1])
    );

    // Reference model: per instance, the last grant and what it captured.
    int          cyc;
    bit          active [2];
    int          gcyc [2];
    bit          own_d [2];
    bit          last_d [2];
    logic [31:0] lat_addr [2];
    logic [31:0] lat_wdata [2];
    logic [3:0]  lat_wmask [2];
    logic [31:0] wcnt [2];
    int          ack_cyc [$];
    bit          ack_isd [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            active[k] = 1'b0; gcyc[k] = 0; own_d[k] = 1'b0; last_d[k] = 1'b1;
            lat_addr[k] = '0; lat_wdata[k] = '0; lat_wmask[k] = '0; wcnt[k] = '0;
        end
        cyc = 0;
    endtask

    // Check the current cycle at the falling edge, then advance the model across the rising edge.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bit issue, resp, ia, da, idle, pick;
            issue = active[k] && (cyc == gcyc[k] + 1);
            resp  = active[k] && (cyc == gcyc[k] + 2);
            ia = resp && !own_d[k];
            da = resp && own_d[k];
            chk($sformatf("c%0d.k%0d.i_ack", cyc, k), {31'd0, i_ack_w[k]}, {31'd0, ia});
            chk($sformatf("c%0d.k%0d.d_ack", cyc, k), {31'd0, d_ack_w[k]}, {31'd0, da});
            chk($sformatf("c%0d.k%0d.i_rdata", cyc, k), i_rdata_w[k], ia ? mem_rdata : 32'd0);
            chk($sformatf("c%0d.k%0d.d_rdata", cyc, k), d_rdata_w[k], da ? mem_rdata : 32'd0);
            chk($sformatf("c%0d.k%0d.rstrb", cyc, k), {31'd0, mem_rstrb_w[k]},
                {31'd0, issue && (lat_wmask[k] == 4'd0)});
            chk($sformatf("c%0d.k%0d.wmask", cyc, k), {28'd0, mem_wmask_w[k]},
                {28'd0, issue ? lat_wmask[k] : 4'd0});
            chk($sformatf("c%0d.k%0d.addr", cyc, k), mem_addr_w[k], lat_addr[k]);
            chk($sformatf("c%0d.k%0d.wdata", cyc, k), mem_wdata_w[k], lat_wdata[k]);
            chk($sformatf("c%0d.k%0d.wait", cyc, k), wait_w[k], wcnt[k]);
            if (k == 0 && (i_ack_w[0] || d_ack_w[0])) begin
                ack_cyc.push_back(cyc);
                ack_isd.push_back(d_ack_w[0]);
            end
            if (i_req && !ia) wcnt[k] = wcnt[k] + 32'd1;
            idle = !active[k] || (cyc >= gcyc[k] + 3);
            if (idle && (i_req || d_req)) begin
                if (i_req && d_req) pick = (k == 0) ? !last_d[k] : 1'b1;
                else                pick = d_req;
                active[k] = 1'b1; gcyc[k] = cyc; own_d[k] = pick; last_d[k] = pick;
                lat_addr[k]  = pick ? d_addr  : i_addr;
                lat_wdata[k] = pick ? d_wdata : 32'd0;
                lat_wmask[k] = pick ? d_wmask : 4'd0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst.k%0d.rstrb", k), {31'd0, mem_rstrb_w[k]}, 32'd0);
            chk($sformatf("rst.k%0d.wmask", k), {28'd0, mem_wmask_w[k]}, 32'd0);
            chk($sformatf("rst.k%0d.acks", k), {30'd0, i_ack_w[k], d_ack_w[k]}, 32'd0);
            chk($sformatf("rst.k%0d.wait", k), wait_w[k], 32'd0);
            chk($sformatf("rst.k%0d.addr", k), mem_addr_w[k], 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Lone instruction fetch.
        i_req = 1'b1; i_addr = 32'h100; mem_rdata = 32'h0000_0013;
        step(); step();
        chk("ifetch.ack_rdata", i_rdata_w[0], 32'h13);
        step();
        i_req = 1'b0;
        repeat (2) step();

        // Lone data write.
        d_req = 1'b1; d_addr = 32'h204; d_wmask = 4'b1100; d_wdata = 32'hABCD_0000;
        step(); step(); step();
        d_req = 1'b0; d_wmask = 4'd0;
        repeat (2) step();

        // Both ports requesting continuously from reset.
        do_reset();
        ack_cyc.delete(); ack_isd.delete();
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_addr = 32'h80;
        repeat (12) step();
        chk("tie.nacks", ack_cyc.size(), 32'd4);
        for (int n = 0; n < 4 && n < ack_cyc.size(); n++) begin
            chk($sformatf("tie.ack%0d.cyc", n), ack_cyc[n], 2 + 3 * n);
            chk($sformatf("tie.ack%0d.isd", n), {31'd0, ack_isd[n]}, {31'd0, n[0]});
        end
        chk("fixed.wait12", wait_w[1], 32'd12);
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) step();

        // Reset while a read is in ISSUE.
        do_reset();
        d_req = 1'b1; d_addr = 32'h400; i_req = 1'b1;
        step();
        reset = 1'b1;
        #1;
        chk("rstissue.rstrb0", {31'd0, mem_rstrb_w[0]}, 32'd0);
        chk("rstissue.rstrb1", {31'd0, mem_rstrb_w[1]}, 32'd0);
        chk("rstissue.wait0", wait_w[0], 32'd0);
        do_reset();
        repeat (4) step();

        // Address changed and request dropped during ISSUE.
        d_req = 1'b1; d_addr = 32'h300;
        step();
        d_req = 1'b0; d_addr = 32'h999;
        step();
        chk("drop.addr", mem_addr_w[0], 32'h300);
        step();
        step();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            i_req     = ($urandom_range(0, 3) != 0);
            d_req     = ($urandom_range(0, 2) == 0);
            i_addr    = $urandom;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            d_wmask   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            mem_rdata = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: RR_MODE, default 1, 1 = round-robin arbitration, 0 = fixed priority with data port winning.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_req  input  1  instruction-fetch request, held until i_ack.
REQ-005 i_addr  input  32  instruction byte address.
REQ-006 i_rdata  output  32  instruction read data, valid while i_ack.
REQ-007 i_ack  output  1  one-cycle completion pulse for the instruction port.
REQ-008 d_req  input  1  data request, held until d_ack.
REQ-009 d_addr  input  32  data byte address.
REQ-010 d_wdata  input  32  store data, already lane-aligned.
REQ-011 d_wmask  input  4  byte-write mask; 0 = read, nonzero = write.
REQ-012 d_rdata  output  32  data read word, valid while d_ack.
REQ-013 d_ack  output  1  one-cycle completion pulse for the data port.
REQ-014 mem_addr  output  32  shared memory address.
REQ-015 mem_rstrb  output  1  read strobe; mem_rdata is valid the following cycle.
REQ-016 mem_wdata  output  32  shared memory write data.
REQ-017 mem_wmask  output  4  shared memory byte-write enables.
REQ-018 mem_rdata  input  32  memory read data.
REQ-019 i_wait_cnt  output  32  count of cycles with i_req high and i_ack low.

Function
REQ-020 The FSM SHALL have three states: IDLE, ISSUE, RESP; IDLE->ISSUE on any request, ISSUE->RESP always, RESP->IDLE always.
REQ-021 In IDLE with requests pending, the arbiter SHALL select exactly one owner and latch owner, address, wdata and wmask (wmask forced to 0 for the instruction port).
REQ-022 On simultaneous i_req and d_req, RR_MODE=1 SHALL grant the port not granted last, and RR_MODE=0 SHALL grant the data port.
REQ-023 The last-grant register SHALL update only on a grant.
REQ-024 In ISSUE, mem_addr/mem_wdata SHALL drive the latched values, mem_rstrb SHALL equal (latched wmask == 0), and mem_wmask SHALL equal the latched wmask.
REQ-025 Outside ISSUE, mem_rstrb and mem_wmask SHALL be 0, and mem_addr/mem_wdata SHALL hold the latched values.
REQ-026 In RESP, the owner's ack SHALL be 1 and its rdata SHALL equal mem_rdata; the other ack SHALL be 0; rdata of a non-acking port SHALL be 0.
REQ-027 Writes SHALL also complete via RESP with ack; rdata on a write ack SHALL equal mem_rdata (don't-care for the requester).
REQ-028 Latency SHALL be fixed: a request seen in IDLE at cycle T acks at cycle T+2; throughput is one transaction per 3 cycles.
REQ-029 Requesters drop or renew req in the cycle after ack; a held req SHALL be treated as a new request in the next IDLE.
REQ-030 Input changes after a grant SHALL be ignored; req withdrawn mid-transaction SHALL NOT cancel it, and the ack still pulses.
REQ-031 i_wait_cnt SHALL increment by 1 each cycle that i_req=1 and i_ack=0, and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-032 reset SHALL immediately force the state to IDLE, set both acks, mem_rstrb and mem_wmask to 0, set latched address/wdata/wmask to 0, set last-grant to data (instruction wins the first tie), and clear i_wait_cnt.
REQ-033 A transaction in flight at reset SHALL be dropped with no ack; the first request after reset release is arbitrated normally.

Verification
REQ-034 i_req only, i_addr=0x100, mem returns 0x00000013 -> mem_rstrb at T+1 with mem_addr=0x100; i_ack=1 and i_rdata=0x13 at T+2; d_ack=0 throughout.
REQ-035 d_req write, d_addr=0x204, wmask=0b1100, wdata=0xABCD0000 -> mem_wmask=0b1100 for exactly one cycle (T+1), mem_rstrb=0; d_ack at T+2.
REQ-036 RR_MODE=1 with both ports continuously requesting from reset -> grant order I, D, I, D; acks at cycles 2, 5, 8, 11.
REQ-037 RR_MODE=0 with both ports requesting -> data port granted every transaction; i_wait_cnt increases by 3 per transaction.
REQ-038 reset asserted during ISSUE -> mem_rstrb drops immediately, no ack follows, and i_wait_cnt=0.
REQ-039 d_addr changed and d_req dropped in the ISSUE cycle -> mem_addr keeps the original address, and d_ack still pulses at T+2.
